// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - HI/LO sequencing around a pipelined 32x32 unsigned multiplier
// Optional accumulate (MADD/MADDU) path: define MULT_HILO_ACCUM_EN.
module mult_hilo_unit #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic        accum,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_r,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] LAT = 4'(MUL_LATENCY);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        neg_q;
    logic        acc_q;
    logic [31:0] mul_a_q;
    logic [31:0] mul_b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic [31:0] mag_a_d;
    logic [31:0] mag_b_d;
    logic        neg_d;
    logic        acc_d;
    logic [63:0] prod_d;
    logic [63:0] hilo_d;
    logic        mt_ok;

    // The multiplier only sees magnitudes; the sign is reapplied at commit.
    always_comb begin
        mag_a_d = (signed_op && op_a[31]) ? (~op_a + 32'd1) : op_a;
        mag_b_d = (signed_op && op_b[31]) ? (~op_b + 32'd1) : op_b;
        neg_d   = signed_op & (op_a[31] ^ op_b[31]);
        prod_d  = neg_q ? (~mul_r + 64'd1) : mul_r;
    end

`ifdef MULT_HILO_ACCUM_EN
    always_comb begin
        acc_d  = accum;
        hilo_d = acc_q ? ({hi_q, lo_q} + prod_d) : prod_d;
    end
`else
    logic unused_accum;
    assign unused_accum = accum;

    always_comb begin
        acc_d  = 1'b0;
        hilo_d = prod_d;
    end
`endif

    // MTHI/MTLO are only honoured when the unit is idle and not issuing.
    assign mt_ok = (state_q == S_IDLE) && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            neg_q   <= 1'b0;
            acc_q   <= 1'b0;
            mul_a_q <= 32'd0;
            mul_b_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mul_a_q <= mag_a_d;
                        mul_b_q <= mag_b_d;
                        neg_q   <= neg_d;
                        acc_q   <= acc_d;
                        cnt_q   <= LAT;
                        state_q <= S_WAIT;
                    end else begin
                        if (mthi_we && mt_ok) begin
                            hi_q <= wdata;
                        end
                        if (mtlo_we && mt_ok) begin
                            lo_q <= wdata;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        hi_q    <= hilo_d[63:32];
                        lo_q    <= hilo_d[31:0];
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = (state_q == S_WAIT);
    assign done  = done_q;
    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - self-checking bench for mult_hilo_unit
module tb_mult_hilo_unit;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic        accum;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] wdata;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_r;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int fails;
    logic [63:0] m_hilo;

    mult_hilo_unit #(.MUL_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .accum(accum), .op_a(op_a), .op_b(op_b), .mthi_we(mthi_we),
        .mtlo_we(mtlo_we), .wdata(wdata), .mul_a(mul_a), .mul_b(mul_b),
        .mul_r(mul_r), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product appears LAT edges after its inputs change.
    logic [63:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_r = pipe[LAT-1];

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [31:0] ref_mag(input logic [31:0] a, input logic s);
        if (s && a[31]) return 32'(0 - a);
        return a;
    endfunction

    // Called and returning at a negedge; leaves the bench on the done cycle.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s, input logic ac);
        int n;
        logic [63:0] p;
        start = 1'b1; signed_op = s; accum = ac; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0; accum = 1'b0;
        tests++;
        if (mul_a !== ref_mag(a, s) || mul_b !== ref_mag(b, s)) begin
            fails++;
            $display("FAIL mul_operands: got %h/%h want %h/%h", mul_a, mul_b, ref_mag(a, s), ref_mag(b, s));
        end
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_early: got %b want 0", done);
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (n != LAT + 1) begin
            fails++;
            $display("FAIL busy_cycles: got %0d want %0d", n, LAT + 1);
        end
        p = ref_prod(a, b, s);
`ifdef MULT_HILO_ACCUM_EN
        m_hilo = ac ? (m_hilo + p) : p;
`else
        m_hilo = p;
`endif
        tests++;
        if (done !== 1'b1 || {hi, lo} !== m_hilo) begin
            fails++;
            $display("FAIL commit: done=%b hilo=%h want done=1 hilo=%h", done, {hi, lo}, m_hilo);
        end
    endtask

    task automatic idle_cycle_check_done_low();
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse_width: got %b want 0", done);
        end
    endtask

    task automatic write_hilo(input logic whi, input logic wlo, input logic [31:0] d);
        mthi_we = whi; mtlo_we = wlo; wdata = d;
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b0;
        if (whi) m_hilo[63:32] = d;
        if (wlo) m_hilo[31:0] = d;
        tests++;
        if ({hi, lo} !== m_hilo) begin
            fails++;
            $display("FAIL mt_write: got %h want %h", {hi, lo}, m_hilo);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; accum = 1'b0;
        op_a = '0; op_b = '0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
        m_hilo = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({mul_a, mul_b, hi, lo} !== 128'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: a=%h b=%h hi=%h lo=%h busy=%b done=%b want all 0",
                     mul_a, mul_b, hi, lo, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        tests++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            fails++;
            $display("FAIL multu_max: got %h_%h want fffffffe_00000001", hi, lo);
        end
        idle_cycle_check_done_low();
        do_mul(32'hFFFFFFFD, 32'd7, 1'b1, 1'b0);
        tests++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            fails++;
            $display("FAIL mult_neg3x7: got %h_%h want ffffffff_ffffffeb", hi, lo);
        end
        idle_cycle_check_done_low();
        do_mul(32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
        tests++;
        if (hi !== 32'h00000006 || lo !== 32'hFFFFFFEB) begin
            fails++;
            $display("FAIL multu_fffffffd_x7: got %h_%h want 00000006_ffffffeb", hi, lo);
        end
        idle_cycle_check_done_low();
        do_mul(32'h80000000, 32'h80000000, 1'b1, 1'b0);
        tests++;
        if (hi !== 32'h40000000 || lo !== 32'h00000000) begin
            fails++;
            $display("FAIL mult_min_neg: got %h_%h want 40000000_00000000", hi, lo);
        end
        idle_cycle_check_done_low();
    endtask

    task automatic test_mthilo_drop();
        write_hilo(1'b1, 1'b0, 32'h12345678);
        write_hilo(1'b0, 1'b1, 32'h00000009);
        tests++;
        if (hi !== 32'h12345678 || lo !== 32'h9) begin
            fails++;
            $display("FAIL mthi_mtlo: got %h_%h want 12345678_00000009", hi, lo);
        end
        // Start with MTLO in the same cycle, then a second start and MTHI while busy.
        start = 1'b1; signed_op = 1'b0; op_a = 32'd2; op_b = 32'd3;
        mtlo_we = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        mtlo_we = 1'b0;
        op_a = 32'd100; op_b = 32'd200; mthi_we = 1'b1; wdata = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0; mthi_we = 1'b0;
        tests++;
        if (hi !== 32'h12345678 || lo !== 32'h9 || mul_a !== 32'd2 || mul_b !== 32'd3) begin
            fails++;
            $display("FAIL drop_while_busy: hilo=%h_%h a=%h b=%h want 12345678_00000009 a=2 b=3",
                     hi, lo, mul_a, mul_b);
        end
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (hi !== 32'd0 || lo !== 32'd6 || busy !== 1'b0) begin
            fails++;
            $display("FAIL drop_final: got %h_%h busy=%b want 00000000_00000006 busy=0", hi, lo, busy);
        end
        m_hilo = 64'd6;
    endtask

    task automatic test_reset_mid_wait();
        int seen_done;
        start = 1'b1; signed_op = 1'b0; accum = 1'b0; op_a = 32'd11; op_b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({mul_a, mul_b, hi, lo} !== 128'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: a=%h b=%h hi=%h lo=%h busy=%b done=%b want all 0",
                     mul_a, mul_b, hi, lo, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_hilo = '0;
        seen_done = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        tests++;
        if (seen_done != 0 || {hi, lo} !== 64'd0) begin
            fails++;
            $display("FAIL reset_abort: activity=%0d hilo=%h want 0 and 0", seen_done, {hi, lo});
        end
        do_mul(32'd11, 32'd13, 1'b0, 1'b0);
        idle_cycle_check_done_low();
    endtask

    task automatic test_accum();
        write_hilo(1'b1, 1'b1, 32'd0);
        write_hilo(1'b0, 1'b1, 32'd5);
        do_mul(32'd2, 32'd3, 1'b0, 1'b1);
        idle_cycle_check_done_low();
        do_mul(32'hFFFFFFFF, 32'd1, 1'b1, 1'b1);
        tests++;
`ifdef MULT_HILO_ACCUM_EN
        if (hi !== 32'd0 || lo !== 32'd10) begin
            fails++;
            $display("FAIL madd_seq: got %h_%h want 00000000_0000000a", hi, lo);
        end
`else
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL madd_seq_noacc: got %h_%h want ffffffff_ffffffff", hi, lo);
        end
`endif
        idle_cycle_check_done_low();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic s, ac;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) a = 32'h80000000;
            if (i % 7 == 0) b = 32'hFFFFFFFF;
            s = 1'($urandom_range(0, 1));
            ac = 1'($urandom_range(0, 1));
            do_mul(a, b, s, ac);
        end
        idle_cycle_check_done_low();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_mthilo_drop();
        test_reset_mid_wait();
        test_accum();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
